// File: rtl/paddle_pot.sv
// Atari 2600 paddle pot/capacitor emulation for one TIA INPTx channel.
// Converts a 7-bit paddle position into a scanline-timed charge delay after VBLANK dump release.
module paddle_pot #(
  parameter int unsigned OFFSET = 2,
  parameter int unsigned SHIFT  = 1,
  parameter bit          INVERT = 1'b0,
  parameter int unsigned CW     = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] pos,
  input  logic       dump,
  input  logic       line_tick,
  output logic       inpt,
  output logic       charging
);

  localparam int unsigned PW = 7;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] ST_DUMPED   = 2'd0;
  localparam logic [SW-1:0] ST_CHARGING = 2'd1;
  localparam logic [SW-1:0] ST_CHARGED  = 2'd2;

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] thr_q, thr_d;
  logic          inpt_q, inpt_d;
  logic          charging_q, charging_d;

  logic [PW-1:0] eff_pos_c;
  logic [CW-1:0] thr_new_c;
  logic          cnt_sat_c;
  logic          thr_hit_c;

  // Position direction and charge threshold for the position seen at dump release
  assign eff_pos_c = INVERT ? PW'(7'd127 - pos) : pos;
  assign thr_new_c = CW'(OFFSET) + (CW'(eff_pos_c) << SHIFT);

  assign cnt_sat_c = (cnt_q == {CW{1'b1}});
  assign thr_hit_c = (cnt_q >= thr_q);

  // Next-state: dump grounds the cap from any state and wins over tick/compare
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;

    if (dump) begin
      state_d = ST_DUMPED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_DUMPED: begin
          state_d = ST_CHARGING;
          thr_d   = thr_new_c;
          cnt_d   = '0;
        end
        ST_CHARGING: begin
          if (thr_hit_c) begin
            state_d = ST_CHARGED;
          end else if (line_tick && !cnt_sat_c) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_CHARGED: begin
          state_d = ST_CHARGED;
        end
        default: begin
          state_d = ST_DUMPED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs follow the next state so they change on the same edge as the state
  always_comb begin
    inpt_d     = (state_d == ST_CHARGED);
    charging_d = (state_d == ST_CHARGING);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_DUMPED;
      cnt_q      <= '0;
      thr_q      <= '0;
      inpt_q     <= 1'b0;
      charging_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      thr_q      <= thr_d;
      inpt_q     <= inpt_d;
      charging_q <= charging_d;
    end
  end

  assign inpt     = inpt_q;
  assign charging = charging_q;

endmodule

// File: tb/tb_paddle_pot.sv
// Bench for paddle_pot: three instances (defaults, OFFSET=0, INVERT=1) sharing stimulus.
module tb_paddle_pot;

  typedef struct {
    string      tag;
    int         dut;
    logic [1:0] oc;   // {inpt, charging}
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] pos;
  logic       dump;
  logic       line_tick;
  logic [2:0] inpt_v;
  logic [2:0] chg_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  paddle_pot u_def (
    .clk(clk), .reset_n(reset_n), .pos(pos), .dump(dump), .line_tick(line_tick),
    .inpt(inpt_v[0]), .charging(chg_v[0])
  );

  paddle_pot #(.OFFSET(0)) u_off0 (
    .clk(clk), .reset_n(reset_n), .pos(pos), .dump(dump), .line_tick(line_tick),
    .inpt(inpt_v[1]), .charging(chg_v[1])
  );

  paddle_pot #(.INVERT(1'b1)) u_inv (
    .clk(clk), .reset_n(reset_n), .pos(pos), .dump(dump), .line_tick(line_tick),
    .inpt(inpt_v[2]), .charging(chg_v[2])
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic d, input logic t);
    dump      = d;
    line_tick = t;
  endtask

  task automatic push_exp(input string tag, input int dut, input logic [1:0] oc);
    exp_t e;
    e.tag = tag;
    e.dut = dut;
    e.oc  = oc;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [1:0] got;
    reset_n = 1'b0; pos = 7'd50; drv(1'b0, 1'b0);
    cyc(); cyc();
    push_exp("reset_state", 0, 2'b00);
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    reset_n = 1'b1;
    push_exp("reset_release_charging", 0, 2'b01);
    cyc();
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
  endtask

  // pos=10 with defaults: threshold 2 + 20 = 22 ticks
  task automatic test_charge_time();
    exp_t e;
    logic [1:0] got;
    int thr = 22;
    pos = 7'd10; drv(1'b1, 1'b0); cyc(); cyc();
    drv(1'b0, 1'b0); push_exp("charge_release", 0, 2'b01); cyc();
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    for (int k = 1; k <= 25; k++) begin
      drv(1'b0, 1'b1);
      push_exp($sformatf("charge_tick%0d", k), 0, (k - 1 >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
      drv(1'b0, 1'b0);
      push_exp($sformatf("charge_idle%0d", k), 0, (k >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
  endtask

  // OFFSET=0 and pos=0 give a zero threshold: charged with no ticks
  task automatic test_zero_threshold();
    exp_t e;
    logic [1:0] got;
    pos = 7'd0; drv(1'b1, 1'b0); cyc(); cyc();
    drv(1'b0, 1'b0);
    push_exp("zero_thr_enter", 1, 2'b01);
    push_exp("zero_thr_charged", 1, 2'b10);
    push_exp("zero_thr_hold", 1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
  endtask

  // pos latched at release; threshold 2 + 254 = 256 even though pos later drops to 0
  task automatic test_pos_latch();
    exp_t e;
    logic [1:0] got;
    int thr = 256;
    pos = 7'd127; drv(1'b1, 1'b0); cyc(); cyc();
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 257; k++) begin
      if (k == 6) pos = 7'd0;
      drv(1'b0, 1'b1); cyc();
      drv(1'b0, 1'b0);
      push_exp($sformatf("latch_idle%0d", k), 0, (k >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
  endtask

  // Abort at tick 8, then a fresh 22-tick charge is required
  task automatic test_redump();
    exp_t e;
    logic [1:0] got;
    int thr = 22;
    pos = 7'd10; drv(1'b1, 1'b0); cyc(); cyc();
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 8; k++) begin
      drv(1'b0, 1'b1); cyc();
      drv(1'b0, 1'b0); cyc();
    end
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, i[0]);
      push_exp($sformatf("redump_hold%0d", i), 0, 2'b00);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 23; k++) begin
      drv(1'b0, 1'b1); cyc();
      drv(1'b0, 1'b0);
      push_exp($sformatf("redump_idle%0d", k), 0, (k >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
  endtask

  // Ticks ignored while charged; dump and tick together clear inpt and the count
  task automatic test_dump_over_tick();
    exp_t e;
    logic [1:0] got;
    int thr = 22;
    pos = 7'd10; drv(1'b1, 1'b0); cyc();
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 22; k++) begin
      drv(1'b0, 1'b1); cyc();
      drv(1'b0, 1'b0); cyc();
    end
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b1);
      push_exp("charged_ignores_tick", 0, 2'b10);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
    drv(1'b1, 1'b1);
    push_exp("dump_with_tick", 0, 2'b00);
    cyc();
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 22; k++) begin
      drv(1'b0, 1'b1); cyc();
      drv(1'b0, 1'b0);
      push_exp($sformatf("recharge_idle%0d", k), 0, (k >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
  endtask

  // INVERT=1, pos=127: effective position 0, threshold = OFFSET = 2
  task automatic test_invert();
    exp_t e;
    logic [1:0] got;
    int thr = 2;
    pos = 7'd127; drv(1'b1, 1'b0); cyc(); cyc();
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 4; k++) begin
      drv(1'b0, 1'b1);
      push_exp($sformatf("invert_tick%0d", k), 2, (k - 1 >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
      drv(1'b0, 1'b0);
      push_exp($sformatf("invert_idle%0d", k), 2, (k >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
  endtask

  // Asynchronous reset in the middle of a charge, then a full restart
  task automatic test_reset_midcharge();
    exp_t e;
    logic [1:0] got;
    int thr = 22;
    pos = 7'd10; drv(1'b1, 1'b0); cyc();
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 5; k++) begin
      drv(1'b0, 1'b1); cyc();
      drv(1'b0, 1'b0); cyc();
    end
    #2 reset_n = 1'b0;
    push_exp("async_reset", 0, 2'b00);
    #1;
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    cyc();
    drv(1'b1, 1'b0);
    reset_n = 1'b1;
    push_exp("post_reset_dumped", 0, 2'b00);
    cyc();
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    drv(1'b0, 1'b0); cyc();
    for (int k = 1; k <= 22; k++) begin
      drv(1'b0, 1'b1); cyc();
      drv(1'b0, 1'b0);
      push_exp($sformatf("post_reset_idle%0d", k), 0, (k >= thr) ? 2'b10 : 2'b01);
      cyc();
      e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
      if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    end
  endtask

  // A single-clock dump release is enough to start charging
  task automatic test_single_clk_release();
    exp_t e;
    logic [1:0] got;
    pos = 7'd10; drv(1'b1, 1'b0); cyc(); cyc();
    drv(1'b0, 1'b0); push_exp("pulse_release", 0, 2'b01); cyc();
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
    drv(1'b1, 1'b0); push_exp("pulse_redump", 0, 2'b00); cyc();
    e = exp_q.pop_front(); got = {inpt_v[e.dut], chg_v[e.dut]}; n_tests++;
    if (got !== e.oc) begin n_fail++; $display("FAIL %s: {inpt,charging}=%b expected %b", e.tag, got, e.oc); end
  endtask

  initial begin
    test_reset();
    test_charge_time();
    test_zero_threshold();
    test_pos_latch();
    test_redump();
    test_dump_over_tick();
    test_invert();
    test_reset_midcharge();
    test_single_clk_release();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
